// File: rtl/mem_access_ctrl.sv
// Byte/half/word/dword load-store engine: aligns requests onto a DATA_W memory bus,
// optionally splitting lane-crossing accesses in two beats (macro MEM_ACCESS_SPLIT_EN).
module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_load,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int OB = $clog2(BE_W);
  localparam bit NO_DWORD = (DATA_W == 32);
`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  // Memory handshake: mem_req is the valid, mem_ack the ready. A beat transfers on a
  // cycle with mem_req && mem_ack; mem_addr/mem_be/mem_we/mem_wdata hold until then.
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;
  state_t state, state_nxt;

  logic              is_load_q;
  logic              sign_ext_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] raw_q;

  logic [OB-1:0]     off;
  logic [BE_W-1:0]   nmask;
  logic [2*BE_W-1:0] span;
  logic [BE_W-1:0]   be0, be1;
  logic              crossing, illegal;
  logic              beat_fire, last_fire;
  logic [DATA_W-1:0] lane_bits, merged, load_result;

  function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] rot_left_bytes(input logic [DATA_W-1:0] din,
                                                       input logic [OB-1:0] sh);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < BE_W; i++) r[8*((i + int'(sh)) % BE_W) +: 8] = din[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rot_right_bytes(input logic [DATA_W-1:0] din,
                                                        input logic [OB-1:0] sh);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < BE_W; i++) r[8*i +: 8] = din[8*((i + int'(sh)) % BE_W) +: 8];
    return r;
  endfunction

  assign off = addr_q[OB-1:0];

  always_comb begin
    nmask = '0;
    for (int i = 0; i < BE_W; i++) nmask[i] = (i < (1 << size_q));
  end

  // Lanes of the whole access laid over two consecutive bus words.
  assign span     = {{BE_W{1'b0}}, nmask} << off;
  assign be0      = span[BE_W-1:0];
  assign be1      = span[2*BE_W-1:BE_W];
  assign crossing = |be1;
  assign illegal  = (NO_DWORD && size_q == 2'b11) || (crossing && !SPLIT);

  always_comb begin
    mem_req = 1'b0;
    mem_be  = '0;
    if (state == BEAT0 && !illegal) begin
      mem_req = 1'b1;
      mem_be  = be0;
    end else if (state == BEAT1) begin
      mem_req = 1'b1;
      mem_be  = be1;
    end
  end

  assign mem_we    = mem_req && !is_load_q;
  assign mem_addr  = {addr_q[31:OB], {OB{1'b0}}} + ((state == BEAT1) ? 32'(BE_W) : 32'd0);
  assign lane_bits = lanes_to_bits(mem_be);
  assign mem_wdata = rot_left_bytes(wdata_q, off) & lane_bits;

  assign busy = (state == BEAT0) || (state == BEAT1);
  assign done = (state == FIN);
  assign err  = (state == FIN) && illegal;

  assign beat_fire = mem_req && mem_ack;
  assign last_fire = beat_fire && (state == BEAT1 || !crossing);
  assign merged    = (raw_q & ~lane_bits) | (mem_rdata & lane_bits);

  // Bring the captured lanes back to bit 0, then zero- or sign-fill above the access.
  always_comb begin
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] keep;
    logic              sbit;
    aligned = rot_right_bytes(merged, off);
    keep    = lanes_to_bits(nmask);
    case (size_q)
      2'b00:   sbit = aligned[7];
      2'b01:   sbit = aligned[15];
      2'b10:   sbit = aligned[31];
      default: sbit = aligned[DATA_W-1];
    endcase
    load_result = (aligned & keep) | ({DATA_W{sign_ext_q & sbit}} & ~keep);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = BEAT0;
      BEAT0: begin
        if (illegal) begin
          state_nxt = FIN;
        end else if (mem_ack) begin
`ifdef MEM_ACCESS_SPLIT_EN
          state_nxt = crossing ? BEAT1 : FIN;
`else
          state_nxt = FIN;
`endif
        end
      end
`ifdef MEM_ACCESS_SPLIT_EN
      BEAT1: if (mem_ack) state_nxt = FIN;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      is_load_q  <= 1'b0;
      sign_ext_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      raw_q      <= '0;
      rdata      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        is_load_q  <= is_load;
        sign_ext_q <= sign_ext;
        size_q     <= size;
        addr_q     <= addr;
        wdata_q    <= wdata;
      end
      if (beat_fire) raw_q <= merged;
      if (last_fire && is_load_q) rdata <= load_result;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (DATA_W=32); split expectations follow MEM_ACCESS_SPLIT_EN.
module tb_mem_access_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, is_load, sign_ext, mem_ack;
  logic [1:0]    size;
  logic [31:0]   addr;
  logic [W-1:0]  wdata, mem_rdata;
  logic          mem_req, mem_we, busy, done, err;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_be;
  logic [W-1:0]  mem_wdata, rdata;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rdata;

  typedef struct {
    logic [31:0]  a;
    logic [1:0]   sz;
    logic         sx;
    logic [W-1:0] rd;
    logic [3:0]   be;
    logic [W-1:0] res;
  } ld_vec_t;
  ld_vec_t ld_tab[4];

  mem_access_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .rdata(rdata), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lanes(input logic [3:0] be);
    logic [W-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [W-1:0] wd);
    start = 1'b1; is_load = ld; size = sz; sign_ext = sx; addr = a; wdata = wd;
    step();
    start = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic e, input logic ld);
    check({tag, "_done"}, {done, err, busy}, {1'b1, e, 1'b0});
    if (ld && !e) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_sb got=empty exp=entry", tag);
      end else begin
        exp_rdata = exp_q.pop_front();
      end
    end
    check({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  task automatic aligned_access(input string tag, input logic ld, input logic [1:0] sz,
                                input logic sx, input logic [31:0] a, input logic [W-1:0] wd,
                                input logic [W-1:0] rd, input logic [3:0] be,
                                input logic [31:0] ea, input logic [W-1:0] ewd);
    issue(ld, sz, sx, a, wd);
    check({tag, "_req"}, {mem_req, mem_we, busy, done}, {1'b1, ~ld, 1'b1, 1'b0});
    check({tag, "_be"}, mem_be, be);
    check({tag, "_addr"}, mem_addr, ea);
    if (!ld) check({tag, "_wdata"}, mem_wdata & lanes(be), ewd);
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0;
    check_done(tag, 1'b0, ld);
    step();
    check({tag, "_pulse"}, {done, busy, mem_req}, 3'b000);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; is_load = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0; exp_rdata = '0;
    ld_tab[0] = '{32'h4002, 2'b01, 1'b1, 32'h9ABC1234, 4'b1100, 32'hFFFF9ABC};
    ld_tab[1] = '{32'h5001, 2'b00, 1'b0, 32'h1234F056, 4'b0010, 32'h000000F0};
    ld_tab[2] = '{32'h4000, 2'b10, 1'b1, 32'h80000001, 4'b1111, 32'h80000001};
    ld_tab[3] = '{32'h4001, 2'b01, 1'b0, 32'h55C3A711, 4'b0110, 32'h0000C3A7};
    step(); step();
    check("rst_ctl", {mem_req, mem_we, mem_be, busy, done, err}, 64'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset_n = 1'b1;
    step();

    // signed byte load from the top lane, done two cycles after start
    exp_q.push_back(32'hFFFFFF80);
    aligned_access("ld_b_sx", 1'b1, 2'b00, 1'b1, 32'h1003, 32'h0,
                   {8'h80, 24'($urandom_range(0, 32'hFFFFFF))}, 4'b1000, 32'h1000, 32'h0);

    // half store into the upper lanes; rdata must stay put
    aligned_access("st_h", 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0000BEEF,
                   32'($urandom), 4'b1100, 32'h2000, 32'hBEEF0000);

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ld_tab[i].res);
      aligned_access($sformatf("ld_tab%0d", i), 1'b1, ld_tab[i].sz, ld_tab[i].sx, ld_tab[i].a,
                     32'h0, ld_tab[i].rd, ld_tab[i].be, ld_tab[i].a & 32'hFFFFFFFC, 32'h0);
    end

    // stalled beat: outputs hold, start pulses ignored, single done
    issue(1'b0, 2'b10, 1'b0, 32'h6000, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; is_load = i[0]; addr = 32'hDEAD0000 + 32'(i); wdata = 32'($urandom);
      step();
      check($sformatf("stall%0d_ctl", i), {mem_req, mem_we, mem_be, busy, done},
            {1'b1, 1'b1, 4'b1111, 1'b1, 1'b0});
      check($sformatf("stall%0d_bus", i), {mem_addr, mem_wdata}, {32'h6000, 32'h11223344});
    end
    start = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_done("stall", 1'b0, 1'b0);
    start = 1'b1; is_load = 1'b1; addr = 32'h7000;
    step();
    start = 1'b0;
    check("fin_start_a", {done, busy, mem_req}, 3'b000);
    step();
    check("fin_start_b", {done, busy, mem_req}, 3'b000);

    // dword on a 32-bit bus is illegal
    issue(1'b1, 2'b11, 1'b0, 32'h7000, 32'h0);
    check("ill_dw_beat", {mem_req, busy, done}, 3'b010);
    step();
    check_done("ill_dw", 1'b1, 1'b1);
    step();
    check("ill_dw_pulse", {done, err, busy}, 3'b000);

`ifdef MEM_ACCESS_SPLIT_EN
    // lane-crossing word load split over two beats
    exp_q.push_back(32'h33221144);
    issue(1'b1, 2'b10, 1'b0, 32'h3003, 32'h0);
    check("split_b0", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'b1000, 32'h3000});
    mem_ack = 1'b1; mem_rdata = {8'h44, 24'($urandom_range(0, 32'hFFFFFF))};
    step();
    check("split_b1", {mem_req, busy, done, mem_be, mem_addr}, {3'b110, 4'b0111, 32'h3004});
    mem_rdata = {8'($urandom_range(0, 255)), 24'h332211};
    step();
    mem_ack = 1'b0;
    check_done("split", 1'b0, 1'b1);
    step();

    // reset while in the second beat of a crossing store
    issue(1'b0, 2'b10, 1'b0, 32'h3003, 32'hAABBCCDD);
    check("rstmid_wd0", {mem_be, mem_wdata}, {4'b1000, 32'hDD000000});
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rstmid_wd1", {mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 4'b0111, 32'h3004, 32'h00AABBCC});
`else
    // lane-crossing word load without splitting is flagged
    issue(1'b1, 2'b10, 1'b0, 32'h3003, 32'h0);
    check("cross_beat", {mem_req, busy, done}, 3'b010);
    step();
    check_done("cross", 1'b1, 1'b1);
    step();

    // reset in the middle of a stalled store
    issue(1'b0, 2'b10, 1'b0, 32'h9000, 32'hAABBCCDD);
    check("rstmid_wd0", {mem_we, mem_be, mem_wdata}, {1'b1, 4'b1111, 32'hAABBCCDD});
`endif
    reset_n = 1'b0; mem_ack = 1'b1;
    step();
    reset_n = 1'b1; mem_ack = 1'b0;
    exp_rdata = '0;
    check("rstmid_ctl", {mem_req, mem_we, mem_be, busy, done, err}, 64'h0);
    check("rstmid_bus", {mem_addr, mem_wdata}, 64'h0);
    check("rstmid_rdata", rdata, exp_rdata);
    step();
    check("rstmid_nodone", {done, busy, mem_req}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; legal values 32 or 64.
REQ-002 Parameter BE_W, default DATA_W/8, byte-enable width; never overridden.
REQ-003 Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- start  in  1  request strobe; accepted only when busy=0.
- is_load  in  1  1=load, 0=store.
- size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
- sign_ext  in  1  sign-extend load result.
- addr  in  32  byte address.
- wdata  in  DATA_W  store data, LSB-justified.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write strobe.
- mem_addr  out  32  bus-aligned address, low log2(BE_W) bits zero.
- mem_be  out  BE_W  byte lanes active this beat.
- mem_wdata  out  DATA_W  store data shifted to lanes.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  beat completion.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  load result, LSB-justified, stable from done until next start.
- err  out  1  one-cycle pulse with done on illegal access.

Function
REQ-004 FSM states IDLE, BEAT0, BEAT1, FIN; reset state IDLE.
REQ-005 IDLE: start=1 latches all request inputs, moves to BEAT0; busy=1 from the next cycle.
REQ-006 BEAT0/BEAT1: mem_req=1, mem_addr/mem_be/mem_we/mem_wdata held constant until mem_ack=1.
REQ-007 Access bytes N = 1<<size; offset o = addr mod BE_W; lanes o..min(o+N,BE_W)-1 enabled in beat 0.
REQ-008 Aligned case (o+N<=BE_W): BEAT0 ack -> FIN.
REQ-009 Crossing case (o+N>BE_W), SPLIT_EN defined: BEAT0 ack -> BEAT1; BEAT1 uses mem_addr+BE_W, lanes 0..(o+N-BE_W-1); BEAT1 ack -> FIN.
REQ-010 mem_wdata = wdata rotated left by 8*o bits, each beat driving its own lanes.
REQ-011 Loads: bytes captured from mem_rdata on each ack, reassembled LSB-justified; bits above 8*N zero, or copies of bit 8*N-1 when sign_ext=1.
REQ-012 Stores: rdata unchanged.
REQ-013 FIN: done=1 for exactly one cycle, busy=0 in FIN, -> IDLE; start in FIN ignored.
REQ-014 Minimum latency: start at cycle T, mem_ack same cycle mem_req rises (T+1) -> done at T+2; split adds one cycle per beat.
REQ-015 Illegal: size=11 with DATA_W=32 -> no mem_req, FIN next cycle, done=1 and err=1.
REQ-016 start while busy=1 is ignored; no queueing.
REQ-017 mem_ack outside BEAT0/BEAT1 is ignored.

Reset
REQ-018 reset_n=0 at a clock edge forces IDLE; mem_req, mem_we, mem_be, busy, done, err=0; mem_addr, mem_wdata, rdata=0.
REQ-019 Reset mid-access abandons the access; no done pulse; a mem_ack in the reset cycle is discarded.

Configuration
REQ-020 Macro MEM_ACCESS_SPLIT_EN: defined -> crossing accesses split per REQ-009; undefined -> BEAT1 absent, crossing access issues no mem_req, FIN next cycle, done=1 and err=1.

Verification
REQ-021 DATA_W=32, load size=00, addr=0x1003, sign_ext=1, mem_rdata=0x80xxxxxx -> mem_be=1000, rdata=0xFFFFFF80, done at T+2.
REQ-022 Store size=01, addr=0x2002, wdata=0x0000BEEF -> mem_addr=0x2000, mem_be=1100, mem_wdata=0xBEEFxxxx, mem_we=1.
REQ-023 SPLIT_EN, load size=10, addr=0x3003, beat rdata 0x44xxxxxx then 0xxx332211 -> be 1000 then 0111, addrs 0x3000/0x3004, rdata=0x33221144.
REQ-024 Same as REQ-023 without SPLIT_EN -> no mem_req, done=1 and err=1 at T+2.
REQ-025 mem_ack held low 5 cycles in BEAT0 -> outputs stable, start pulses ignored, single done after ack.
REQ-026 reset_n=0 during BEAT1 -> next cycle IDLE, all outputs at reset values, no done.
